// File: rtl/aes_ctrl_fsm.sv
// Load/process/store sequencer for the AES HWPE engine: four input words, a fixed
// processing interval, four output words per block. Optional watchdog: AES_CTRL_TIMEOUT_EN.
module aes_ctrl_fsm #(
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned PROC_CYCLES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             out_ready_i,
  output logic [1:0]       request_counter_o,
  output logic             data_out_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] block_cnt_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PROCESS = 3'd2,
    STORE   = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e           state_r;
  logic [1:0]       word_cnt_r;
  logic [LEN_W-1:0] block_cnt_r;
  logic [LEN_W-1:0] len_r;
  logic [7:0]       proc_cnt_r;
  logic [LEN_W-1:0] block_nxt_s;

  assign block_nxt_s = block_cnt_r + LEN_W'(1);

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wdog_r;
  logic           err_r;
  logic           stall_s;
  logic           timeout_s;

  // A stall is a cycle in a transfer state without the partner's handshake.
  assign stall_s   = ((state_r == LOAD) && !in_valid_i) || ((state_r == STORE) && !out_ready_i);
  assign timeout_s = stall_s && (wdog_r == WdW'(TIMEOUT_CYCLES - 1));
  assign err_o     = err_r;
`else
  assign err_o = 1'b0;
`endif

  // Sequencer state, word/block/process counters and optional watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      word_cnt_r  <= 2'd0;
      block_cnt_r <= '0;
      len_r       <= '0;
      proc_cnt_r  <= 8'd0;
`ifdef AES_CTRL_TIMEOUT_EN
      wdog_r      <= '0;
      err_r       <= 1'b0;
`endif
    end else if (clear_i) begin
      state_r     <= IDLE;
      word_cnt_r  <= 2'd0;
      block_cnt_r <= '0;
      proc_cnt_r  <= 8'd0;
`ifdef AES_CTRL_TIMEOUT_EN
      wdog_r      <= '0;
      err_r       <= 1'b0;
`endif
    end else begin
`ifdef AES_CTRL_TIMEOUT_EN
      if (stall_s) begin
        wdog_r <= wdog_r + WdW'(1);
      end else begin
        wdog_r <= '0;
      end
`endif
      case (state_r)
        IDLE: begin
          if (start_i) begin
            word_cnt_r  <= 2'd0;
            block_cnt_r <= '0;
`ifdef AES_CTRL_TIMEOUT_EN
            err_r       <= 1'b0;
`endif
            if (len_i != '0) begin
              len_r   <= len_i;
              state_r <= LOAD;
            end else begin
              state_r <= DONE;
            end
          end
        end
        LOAD: begin
          if (in_valid_i) begin
            word_cnt_r <= word_cnt_r + 2'd1;
            if (word_cnt_r == 2'd3) begin
              proc_cnt_r <= 8'(PROC_CYCLES);
              state_r    <= PROCESS;
            end
          end
`ifdef AES_CTRL_TIMEOUT_EN
          else if (timeout_s) begin
            err_r   <= 1'b1;
            state_r <= DONE;
          end
`endif
        end
        PROCESS: begin
          if (proc_cnt_r == 8'd1) begin
            state_r <= STORE;
          end else begin
            proc_cnt_r <= proc_cnt_r - 8'd1;
          end
        end
        STORE: begin
          if (out_ready_i) begin
            word_cnt_r <= word_cnt_r + 2'd1;
            if (word_cnt_r == 2'd3) begin
              block_cnt_r <= block_nxt_s;
              state_r     <= (block_nxt_s == len_r) ? DONE : LOAD;
            end
          end
`ifdef AES_CTRL_TIMEOUT_EN
          else if (timeout_s) begin
            err_r   <= 1'b1;
            state_r <= DONE;
          end
`endif
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_ready_o        = (state_r == LOAD);
  assign data_out_valid_o  = (state_r == STORE);
  assign busy_o            = (state_r != IDLE);
  assign done_o            = (state_r == DONE);
  assign request_counter_o = word_cnt_r;
  assign block_cnt_o       = block_cnt_r;

endmodule

// File: doc/aes_ctrl_fsm.md
# aes_ctrl_fsm

Sequencer for the AES HWPE datapath. It drives the engine's word index (`request_counter`) and output-valid control: 128-bit blocks are loaded as four 32-bit words from the input stream, held for a programmable processing interval, then streamed out as four words. It sits between the HWPE register file/controller and the AES engine. It runs a job of N blocks per start command and reports busy/done to the controller.

## Interface
Parameters:
- `LEN_W`, 16: width of the block-count job length.
- `PROC_CYCLES`, 1: cycles spent in PROCESS per block; legal range 1..255.
- `TIMEOUT_CYCLES`, 1024: stall limit, used only when the timeout feature is compiled in.

Ports:
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `clear_i` in, 1: synchronous soft clear.
- `start_i` in, 1: job start pulse.
- `len_i` in, `LEN_W`: number of blocks in the job; sampled on an accepted start.
- `in_valid_i` in, 1: input stream valid.
- `in_ready_o` out, 1: input stream ready; also enables the engine's word capture.
- `out_ready_i` in, 1: output stream ready.
- `request_counter_o` out, 2: word index 0..3 to the engine.
- `data_out_valid_o` out, 1: output stream valid, driven to the engine.
- `busy_o` out, 1: high while the state is not IDLE.
- `done_o` out, 1: one-cycle completion pulse.
- `block_cnt_o` out, `LEN_W`: blocks completed in the current job.
- `err_o` out, 1: sticky timeout error.

## Operation
States: IDLE, LOAD, PROCESS, STORE, DONE. State is registered.

IDLE
- `start_i` with `len_i` not 0: latch `len_i`, clear `word_cnt` and `block_cnt`, clear `err_o`, then go to LOAD.
- `start_i` with `len_i` equal to 0: go to DONE, so `done_o` pulses once and no transfers occur.

LOAD
- `in_ready_o` is 1.
- Each cycle with `in_valid_i` high is one accepted word, and `word_cnt` increments.
- When word 3 is accepted, `word_cnt` wraps to 0 and the next state is PROCESS.

PROCESS
- A down-counter is loaded with `PROC_CYCLES`.
- The state is exited to STORE when the counter reaches 1, so PROCESS lasts exactly `PROC_CYCLES` cycles.

STORE
- `data_out_valid_o` is 1.
- Each cycle with `out_ready_i` high is one handshake, and `word_cnt` increments.
- When word 3 is handshaken:
  - `word_cnt` wraps to 0 and `block_cnt` increments.
  - If the new `block_cnt` equals the latched length, the next state is DONE; otherwise it is LOAD.

DONE
- `done_o` is 1 for exactly one cycle, then the state returns to IDLE.

Common rules:
- `request_counter_o` equals `word_cnt` in every state.
- `start_i` is ignored while `busy_o` is 1.
- `clear_i` has priority over all other inputs. It forces IDLE and zeroes `word_cnt`, `block_cnt`, the PROCESS counter, the watchdog and `err_o`. No `done_o` pulse is generated.
- `block_cnt_o` holds its final value in IDLE until the next accepted start or clear.
- All counter arithmetic is modulo width. The latched length is at most 2^`LEN_W`−1, so `block_cnt` never wraps within a job.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- `in_ready_o`, `data_out_valid_o`, `busy_o` and `done_o` are decoded combinationally from the registered state only. None of them depends on `in_valid_i` or `out_ready_i`.
- `request_counter_o` is registered. It changes in the cycle after a handshake, so the engine always sees the index of the current beat.
- `start_i` is accepted in cycle t, and `busy_o` is 1 from t+1.
- Per-block minimum duration with no stalls: 4 (LOAD) + `PROC_CYCLES` + 4 (STORE) cycles.
- Job end: DONE follows the final STORE beat by 1 cycle. `busy_o` falls in the cycle after the `done_o` pulse.
- Stalls: the FSM holds its state and `word_cnt` indefinitely while `in_valid_i` or `out_ready_i` is 0. `data_out_valid_o` is never dropped mid-STORE.
- Asserting `rst_ni` low mid-job drops all outputs to 0 immediately (asynchronous). There is no output completion.

## Configuration
Macro: `AES_CTRL_TIMEOUT_EN`.

Defined:
- A watchdog counts consecutive stall cycles, meaning LOAD with `in_valid_i` low or STORE with `out_ready_i` low. It resets to 0 on every handshake and on every state change.
- When the count reaches `TIMEOUT_CYCLES`, `err_o` is set to 1 and the next state is DONE, so `done_o` pulses. `err_o` stays 1 until the next accepted start, a clear, or reset.

Not defined:
- No watchdog logic exists, `err_o` is tied to 0, and stalls are unbounded.

## Test plan
- Reset check: release `rst_ni`; then `start_i` with `len_i`=1, `PROC_CYCLES`=1, and `in_valid_i`/`out_ready_i` held high.
  - All outputs are 0 before the start.
  - `request_counter_o` steps 0,1,2,3 in LOAD and again in STORE.
  - `done_o` pulses 10 cycles after the start, and `block_cnt_o` ends at 1.
- Multi-block with stalls: `len_i`=3; `in_valid_i` toggles 1/0; `out_ready_i` is low for 5 cycles in block 2.
  - Exactly 12 input and 12 output handshakes occur.
  - The index holds during stalls, and `block_cnt_o` ends at 3.
- Zero length: `start_i` with `len_i`=0.
  - `done_o` pulses at t+1, `in_ready_o` and `data_out_valid_o` are never high, and `block_cnt_o` is 0.
- Restart while busy and mid-job clear:
  - A second `start_i` during block 1 of a `len_i`=2 job is ignored, and the job completes with `block_cnt_o`=2.
  - `clear_i` during STORE word 2 gives IDLE on the next cycle, all counters at 0, and no `done_o`.
- Mid-job reset: drive `rst_ni` low during PROCESS.
  - Outputs are 0 asynchronously.
  - After release, a new `len_i`=1 job runs normally.
- Timeout, with `AES_CTRL_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=8: hold `in_valid_i` low after word 1.
  - `err_o`=1 and `done_o` pulses exactly 8 stall cycles later, then IDLE.
  - The next start clears `err_o`.
  - With the macro undefined, the FSM waits in LOAD indefinitely and `err_o` stays 0.
